// File: rtl/video_roi_gray_4.sv
// video_roi_gray_4: RGB-to-luma conversion with fixed ROI crop and frame framing checks
module video_roi_gray_4 #(
    parameter int IMG_W = 1280,
    parameter int IMG_H = 720,
    parameter int ROI_X = 608,
    parameter int ROI_Y = 328,
    parameter int ROI_W = 64,
    parameter int ROI_H = 64
) (
    input  logic        s_axis_video_aclk,
    input  logic        rst,
    input  logic [95:0] VIDEO_IN_tdata,
    input  logic        VIDEO_IN_tvalid,
    output logic        VIDEO_IN_tready,
    input  logic        VIDEO_IN_tuser,
    input  logic        VIDEO_IN_tlast,
    output logic [31:0] VIDEO_OUT_tdata,
    output logic        VIDEO_OUT_tvalid,
    input  logic        VIDEO_OUT_tready,
    output logic        VIDEO_OUT_tuser,
    output logic        VIDEO_OUT_tlast,
    output logic        eol_err,
    output logic        sof_err,
    output logic        roi_done
);
    localparam int HB = IMG_W / 4;
    localparam int HW = $clog2(HB + 1);
    localparam int VW = $clog2(IMG_H + 1);
    localparam logic [HW-1:0] H_LAST = HW'(HB - 1);
    localparam logic [HW-1:0] X_FIRST = HW'(ROI_X / 4);
    localparam logic [HW-1:0] X_LAST = HW'((ROI_X + ROI_W) / 4 - 1);
    localparam logic [VW-1:0] V_LAST = VW'(IMG_H - 1);
    localparam logic [VW-1:0] Y_FIRST = VW'(ROI_Y);
    localparam logic [VW-1:0] Y_LAST = VW'(ROI_Y + ROI_H - 1);
    localparam logic [0:0] WAIT_SOF = 1'b0;
    localparam logic [0:0] ACTIVE = 1'b1;

    logic [0:0]    state;
    logic [HW-1:0] hcnt, cur_h;
    logic [VW-1:0] vcnt, cur_v;
    logic          en, acc, proc, line_end, in_roi, eol_hit, sof_hit;
    logic          s1_valid, s1_user, s1_last, s1_done;
    logic [15:0]   s1_pr [4];
    logic [15:0]   s1_pg [4];
    logic [15:0]   s1_pb [4];
    logic          s2_valid, s2_user, s2_last, s2_done;
    logic [31:0]   s2_data, luma;
    logic [15:0]   sum;

    assign en               = ~s2_valid | VIDEO_OUT_tready;
    assign VIDEO_IN_tready  = en & ~rst;
    assign acc              = VIDEO_IN_tvalid & VIDEO_IN_tready;
    assign VIDEO_OUT_tvalid = s2_valid;
    assign VIDEO_OUT_tdata  = s2_data;
    assign VIDEO_OUT_tuser  = s2_user;
    assign VIDEO_OUT_tlast  = s2_last;
    assign roi_done         = s2_valid & VIDEO_OUT_tready & s2_done;

    // Position of the accepted beat; any tuser beat restarts the frame at (0,0)
    always_comb begin
        cur_h    = VIDEO_IN_tuser ? '0 : hcnt;
        cur_v    = VIDEO_IN_tuser ? '0 : vcnt;
        proc     = acc & ((state == ACTIVE) | VIDEO_IN_tuser);
        line_end = VIDEO_IN_tlast | (cur_h == H_LAST);
        eol_hit  = proc & (VIDEO_IN_tlast ^ (cur_h == H_LAST));
        sof_hit  = acc & (state == ACTIVE) & VIDEO_IN_tuser & ((hcnt != '0) | (vcnt != '0));
        in_roi   = proc & (cur_h >= X_FIRST) & (cur_h <= X_LAST) & (cur_v >= Y_FIRST) & (cur_v <= Y_LAST);
    end

    // Framing FSM, line/frame counters and registered error pulses
    always_ff @(posedge s_axis_video_aclk) begin
        if (rst) begin
            state   <= WAIT_SOF;
            hcnt    <= '0;
            vcnt    <= '0;
            eol_err <= 1'b0;
            sof_err <= 1'b0;
        end else begin
            eol_err <= eol_hit;
            sof_err <= sof_hit;
            if (proc) begin
                state <= (line_end & (cur_v == V_LAST)) ? WAIT_SOF : ACTIVE;
                hcnt  <= line_end ? '0 : cur_h + 1'b1;
                vcnt  <= line_end ? ((cur_v == V_LAST) ? '0 : cur_v + 1'b1) : cur_v;
            end
        end
    end

    // Stage 1: per-channel weighted products plus ROI flag and sideband
    always_ff @(posedge s_axis_video_aclk) begin
        if (rst) begin
            s1_valid <= 1'b0;
            s1_user  <= 1'b0;
            s1_last  <= 1'b0;
            s1_done  <= 1'b0;
        end else if (en) begin
            s1_valid <= in_roi;
            s1_user  <= (cur_h == X_FIRST) & (cur_v == Y_FIRST);
            s1_last  <= cur_h == X_LAST;
            s1_done  <= (cur_h == X_LAST) & (cur_v == Y_LAST);
            for (int k = 0; k < 4; k++) begin
                s1_pr[k] <= 16'd77 * {8'd0, VIDEO_IN_tdata[24*k+16 +: 8]};
                s1_pg[k] <= 16'd150 * {8'd0, VIDEO_IN_tdata[24*k +: 8]};
                s1_pb[k] <= 16'd29 * {8'd0, VIDEO_IN_tdata[24*k+8 +: 8]};
            end
        end
    end

    // Rounded sum of products; the top byte is the luma value
    always_comb begin
        luma = '0;
        sum  = '0;
        for (int k = 0; k < 4; k++) begin
            sum             = s1_pr[k] + s1_pg[k] + s1_pb[k] + 16'd128;
            luma[8*k +: 8]  = sum[15:8];
        end
    end

    // Stage 2: output register, held while downstream stalls a valid beat
    always_ff @(posedge s_axis_video_aclk) begin
        if (rst) begin
            s2_valid <= 1'b0;
            s2_user  <= 1'b0;
            s2_last  <= 1'b0;
            s2_done  <= 1'b0;
            s2_data  <= '0;
        end else if (en) begin
            s2_valid <= s1_valid;
            s2_user  <= s1_valid & s1_user;
            s2_last  <= s1_valid & s1_last;
            s2_done  <= s1_valid & s1_done;
            s2_data  <= luma;
        end
    end
endmodule

// File: tb/tb_video_roi_gray_4.sv
// tb_video_roi_gray_4: randomized scoreboard bench for the ROI luma cropper
module tb_video_roi_gray_4;
    localparam int IMG_W = 32;
    localparam int IMG_H = 16;
    localparam int ROI_X = 8;
    localparam int ROI_Y = 4;
    localparam int ROI_W = 16;
    localparam int ROI_H = 6;
    localparam int HB = IMG_W / 4;
    localparam int X0 = ROI_X / 4;
    localparam int X1 = (ROI_X + ROI_W) / 4;
    localparam int ROI_BEATS = (ROI_W / 4) * ROI_H;

    typedef struct {
        logic [31:0] d;
        bit          u;
        bit          l;
        bit          dn;
        int          c;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [95:0] in_data = '0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic        in_user = 1'b0;
    logic        in_last = 1'b0;
    logic [31:0] out_data;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic        out_user;
    logic        out_last;
    logic        eol_err, sof_err, roi_done;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int pix_mode = 0;
    bit in_gap = 0;
    bit rdy_mode = 0;
    bit chk_lat = 0;
    int n_out, n_user, n_last, n_done, n_eol, n_sof;
    logic [31:0] last_data;
    exp_t q[$];
    bit act = 0;
    int h = 0;
    int v = 0;
    bit exp_eol = 0;
    bit exp_sof = 0;
    bit prev_stall = 0;
    logic [31:0] prev_data;
    bit prev_user, prev_last;

    video_roi_gray_4 #(
        .IMG_W(IMG_W), .IMG_H(IMG_H), .ROI_X(ROI_X),
        .ROI_Y(ROI_Y), .ROI_W(ROI_W), .ROI_H(ROI_H)
    ) dut (
        .s_axis_video_aclk(clk),
        .rst(rst),
        .VIDEO_IN_tdata(in_data),
        .VIDEO_IN_tvalid(in_valid),
        .VIDEO_IN_tready(in_ready),
        .VIDEO_IN_tuser(in_user),
        .VIDEO_IN_tlast(in_last),
        .VIDEO_OUT_tdata(out_data),
        .VIDEO_OUT_tvalid(out_valid),
        .VIDEO_OUT_tready(out_ready),
        .VIDEO_OUT_tuser(out_user),
        .VIDEO_OUT_tlast(out_last),
        .eol_err(eol_err),
        .sof_err(sof_err),
        .roi_done(roi_done)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] luma(int r, int g, int b);
        return 8'((77 * r + 150 * g + 29 * b + 128) / 256);
    endfunction

    function automatic logic [95:0] gen_beat();
        logic [95:0] d;
        if (pix_mode == 1) d = {12{8'hFF}};
        else if (pix_mode == 2) d = {4{8'd100, 8'd200, 8'd50}};
        else d = {$urandom, $urandom, $urandom};
        return d;
    endfunction

    function automatic void model_beat(logic [95:0] d, bit u, bit l, int c);
        exp_t e;
        if (!act && !u) return;
        if (u) begin
            if (act && (h != 0 || v != 0)) exp_sof = 1;
            h = 0;
            v = 0;
        end
        act = 1;
        if (h >= X0 && h < X1 && v >= ROI_Y && v < ROI_Y + ROI_H) begin
            for (int k = 0; k < 4; k++)
                e.d[8*k +: 8] = luma(int'(d[24*k+16 +: 8]), int'(d[24*k +: 8]), int'(d[24*k+8 +: 8]));
            e.u = (h == X0 && v == ROI_Y);
            e.l = (h == X1 - 1);
            e.dn = e.l && (v == ROI_Y + ROI_H - 1);
            e.c = c;
            q.push_back(e);
        end
        if ((l && h != HB - 1) || (!l && h == HB - 1)) exp_eol = 1;
        if (l || h == HB - 1) begin
            h = 0;
            v++;
            if (v == IMG_H) begin
                act = 0;
                v = 0;
            end
        end else h++;
    endfunction

    initial forever begin
        @(posedge clk);
        #1;
        out_ready = rdy_mode ? ($urandom_range(0, 2) != 0) : 1'b1;
    end

    always @(negedge clk) begin
        exp_t e;
        cyc++;
        if (rst) begin
            q.delete();
            act = 0;
            h = 0;
            v = 0;
            exp_eol = 0;
            exp_sof = 0;
            prev_stall = 0;
        end else begin
            checks++;
            if (eol_err !== exp_eol) begin
                errors++;
                $display("FAIL eol_err cyc %0d got %b exp %b", cyc, eol_err, exp_eol);
            end
            checks++;
            if (sof_err !== exp_sof) begin
                errors++;
                $display("FAIL sof_err cyc %0d got %b exp %b", cyc, sof_err, exp_sof);
            end
            n_eol += int'(eol_err);
            n_sof += int'(sof_err);
            exp_eol = 0;
            exp_sof = 0;
            if (prev_stall) begin
                checks++;
                if (out_valid !== 1'b1 || out_data !== prev_data || out_user !== prev_user || out_last !== prev_last) begin
                    errors++;
                    $display("FAIL stall_hold cyc %0d got v%b %h exp v1 %h", cyc, out_valid, out_data, prev_data);
                end
            end
            if (out_valid && !out_ready) begin
                checks++;
                if (in_ready !== 1'b0) begin
                    errors++;
                    $display("FAIL in_ready_stall cyc %0d got %b exp 0", cyc, in_ready);
                end
            end
            if (out_valid && out_ready) begin
                if (q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_out cyc %0d got %h exp none", cyc, out_data);
                end else begin
                    e = q.pop_front();
                    checks++;
                    if (out_data !== e.d || out_user !== e.u || out_last !== e.l) begin
                        errors++;
                        $display("FAIL out_beat cyc %0d got %h u%b l%b exp %h u%b l%b",
                                 cyc, out_data, out_user, out_last, e.d, e.u, e.l);
                    end
                    checks++;
                    if (roi_done !== e.dn) begin
                        errors++;
                        $display("FAIL roi_done cyc %0d got %b exp %b", cyc, roi_done, e.dn);
                    end
                    if (chk_lat) begin
                        checks++;
                        if (cyc - e.c != 2) begin
                            errors++;
                            $display("FAIL latency cyc %0d got %0d exp 2", cyc, cyc - e.c);
                        end
                    end
                    n_out++;
                    n_user += int'(out_user);
                    n_last += int'(out_last);
                    n_done += int'(roi_done);
                    last_data = out_data;
                end
            end else if (roi_done) begin
                checks++;
                errors++;
                $display("FAIL roi_done_idle cyc %0d got 1 exp 0", cyc);
            end
            prev_stall = out_valid && !out_ready;
            prev_data = out_data;
            prev_user = out_user;
            prev_last = out_last;
            if (in_valid && in_ready) model_beat(in_data, in_user, in_last, cyc);
        end
    end

    task automatic clr_cnt();
        n_out = 0; n_user = 0; n_last = 0; n_done = 0; n_eol = 0; n_sof = 0;
        last_data = '0;
    endtask

    task automatic chk(input string name, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s got %0d exp %0d", name, got, exp);
        end
    endtask

    task automatic send_beat(input bit u, input bit l);
        int n = 0;
        bit ok = 0;
        if (in_gap) repeat ($urandom_range(0, 2)) begin
            in_valid = 0;
            @(posedge clk);
            #1;
        end
        in_data = gen_beat();
        in_user = u;
        in_last = l;
        in_valid = 1;
        while (!ok && n < 1000) begin
            @(negedge clk);
            ok = in_ready;
            @(posedge clk);
            #1;
            n++;
        end
        if (!ok) begin
            checks++;
            errors++;
            $display("FAIL in_accept timeout got 0 exp 1");
        end
        in_valid = 0;
        in_user = 0;
        in_last = 0;
    endtask

    task automatic send_line(input int len, input bit last_at_end, input bit user_first);
        for (int i = 0; i < len; i++) send_beat(user_first && i == 0, last_at_end && i == len - 1);
    endtask

    task automatic send_frame(input bit with_user);
        for (int l = 0; l < IMG_H; l++) send_line(HB, 1, with_user && l == 0);
    endtask

    task automatic drain();
        int n = 0;
        while ((q.size() != 0 || out_valid) && n < 1000) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (n >= 1000) begin
            checks++;
            errors++;
            $display("FAIL drain timeout got %0d pending exp 0", q.size());
        end
        repeat (3) @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_tvalid", int'(out_valid), 0);
        chk("rst_tuser", int'(out_user), 0);
        chk("rst_tlast", int'(out_last), 0);
        chk("rst_tdata", int'(out_data), 0);
        chk("rst_in_ready", int'(in_ready), 0);
        chk("rst_errs", int'({eol_err, sof_err, roi_done}), 0);
        @(posedge clk);
        #1;
        rst = 0;
        @(negedge clk);
        chk("in_ready_after_rst", int'(in_ready), 1);
        @(posedge clk);
        #1;
    endtask

    task automatic test_uniform_white();
        clr_cnt();
        pix_mode = 1; in_gap = 0; rdy_mode = 0; chk_lat = 1;
        send_frame(1);
        drain();
        chk_lat = 0;
        chk("white_beats", n_out, ROI_BEATS);
        chk("white_tuser", n_user, 1);
        chk("white_tlast", n_last, ROI_H);
        chk("white_done", n_done, 1);
        chk("white_data", int'(last_data == 32'hFFFFFFFF), 1);
        chk("white_eol", n_eol, 0);
    endtask

    task automatic test_fixed_pixel();
        clr_cnt();
        pix_mode = 2;
        send_frame(1);
        drain();
        chk("fixed_beats", n_out, ROI_BEATS);
        chk("fixed_data", int'(last_data == 32'h52525252), 1);
    endtask

    task automatic test_back_to_back();
        clr_cnt();
        pix_mode = 0; in_gap = 1; rdy_mode = 1;
        send_frame(1);
        send_frame(1);
        drain();
        rdy_mode = 0; in_gap = 0;
        chk("bp_beats", n_out, 2 * ROI_BEATS);
        chk("bp_done", n_done, 2);
        chk("bp_tuser", n_user, 2);
    endtask

    task automatic test_line_length();
        clr_cnt();
        rdy_mode = 1;
        for (int l = 0; l < IMG_H; l++) begin
            if (l == 2) send_line(3, 1, 0);
            else if (l == 12) send_line(HB, 0, 0);
            else send_line(HB, 1, l == 0);
        end
        drain();
        rdy_mode = 0;
        chk("ll_eol", n_eol, 2);
        chk("ll_beats", n_out, ROI_BEATS);
        chk("ll_done", n_done, 1);
    endtask

    task automatic test_sof_restart();
        clr_cnt();
        for (int l = 0; l < 6; l++) send_line(HB, 1, l == 0);
        send_line(5, 0, 0);
        send_frame(1);
        drain();
        chk("sof_pulses", n_sof, 1);
        chk("sof_beats", n_out, 8 + 3 + ROI_BEATS);
        chk("sof_tuser", n_user, 2);
        chk("sof_done", n_done, 1);
    endtask

    task automatic test_reset_mid();
        for (int l = 0; l < 6; l++) send_line(HB, 1, l == 0);
        send_line(3, 0, 0);
        rst = 1;
        @(posedge clk);
        #1;
        rst = 0;
        clr_cnt();
        send_frame(0);
        drain();
        chk("rm_no_output", n_out, 0);
        chk("rm_no_eol", n_eol, 0);
        send_frame(1);
        drain();
        chk("rm_beats", n_out, ROI_BEATS);
        chk("rm_done", n_done, 1);
    endtask

    initial begin
        clr_cnt();
        test_reset();
        test_uniform_white();
        test_fixed_pixel();
        test_back_to_back();
        test_line_length();
        test_sof_restart();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
